mac_pipe: RTL and testbench
===========================

Name: mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit; successor to the plain combinational multiplier.
- Accepts a stream of operand pairs with valid/ready and a last flag, and accumulates the products.
- On the last beat it emits one shifted, saturated result per vector.
- Used as the dot-product primitive in convolution and fully-connected layers.

Parameters:
- BITWIDTH, 8: signed operand width of a and b.
- ACC_WIDTH, 32: internal accumulator width; must be >= 2*BITWIDTH.
- OUT_WIDTH, 16: result width; must be <= ACC_WIDTH.
- SHIFT, 0: arithmetic right shift applied to the final sum before saturation; range 0..ACC_WIDTH-1.
- MAX_LEN, 1024: maximum beats per vector; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_last  in  1  beat is the final beat of the vector.
- a  in  BITWIDTH  signed operand.
- b  in  BITWIDTH  signed operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_WIDTH  signed saturated result.
- out_sat  out  1  saturation occurred on this result.
- out_len_err  out  1  vector was force-closed at MAX_LEN.

Behaviour:
- Reset: all pipeline valids 0, accumulator 0, beat counter 0, state IDLE. out_valid=0, out_data=0, out_sat=0, out_len_err=0. in_ready=1 from the first cycle after reset.
- Reset mid-vector or with a pending result: the partial sum and the undelivered result are discarded with no output.
- Global enable: en = !out_valid || out_ready. in_ready = en. When en=0 every stage holds and out_* stay stable.
- A beat is accepted when in_valid && in_ready.
- Pipeline stages:
  - P1 registers a, b, last.
  - P2 registers the full 2*BITWIDTH signed product, sign-extended to ACC_WIDTH.
  - ACC adds the P2 product to the accumulator.
- Latency: a beat accepted at edge N with last=1 gives out_valid=1 after edge N+3.
- Back-to-back vectors run without bubbles. On a last beat the result register receives acc+product and the accumulator loads 0. The first beat of the next vector therefore adds to 0 in the following cycle.
- Accumulator arithmetic is two's complement and wraps silently at ACC_WIDTH.
- Result path: s = sum >>> SHIFT, arithmetic shift.
  - If s > 2^(OUT_WIDTH-1)-1: out_data = max, out_sat=1.
  - If s < -2^(OUT_WIDTH-1): out_data = min, out_sat=1.
  - Otherwise out_data = s[OUT_WIDTH-1:0], out_sat=0.
- State machine, tracked at ACC-stage input:
  - IDLE: no partial sum. A P2-valid beat without last goes to ACCUM with count=1. A beat with last emits a result and stays in IDLE.
  - ACCUM: each beat increments count. A last beat emits a result and goes to IDLE.
  - Length limit: if count reaches MAX_LEN-1 and a further beat arrives without last, that beat is treated as last and out_len_err=1 for that result. Return to IDLE.
- out_len_err and out_sat are valid only while out_valid=1 and are held with out_data.
- Result handshake: the result is consumed when out_valid && out_ready. If a new result is produced in the same cycle, out_valid stays 1 with the new data. Otherwise out_valid falls to 0.
- MAX_LEN=1: every beat is a complete vector.

Optional Feature:
- Macro MAC_PIPE_ROUND_EN.
- When defined and SHIFT>0: add 2^(SHIFT-1) to the sum before the shift (round half up), computed in ACC_WIDTH+1 bits so it cannot wrap. Saturation is applied afterwards.
- When undefined, or SHIFT=0: plain arithmetic shift (floor). Latency is identical in both builds.

Test Plan:
- Defaults; single beat a=3, b=4, last=1 accepted at edge 0 -> out_valid after edge 3, out_data=12, out_sat=0, out_len_err=0.
- Four beats a=1,2,3,4 with b=2, last on the 4th, then immediately a=-5, b=7, last=1 -> results 20 then -35 on consecutive cycles, no bubble.
- Four beats a=-128, b=-128 (sum 65536) -> out_data=32767, out_sat=1. Three beats a=127, b=-128 (sum -48768) -> out_data=-32768, out_sat=1.
- Result pending with out_ready=0 for 5 cycles -> in_ready=0 and out_data stable throughout. When out_ready=1, the next result follows with correct values.
- SHIFT=2, sums 6 and -6 -> floor build gives 1 and -2. MAC_PIPE_ROUND_EN build gives 2 and -1.
- MAX_LEN=4, six beats of a=1, b=1 with no last -> first result 4 with out_len_err=1. rst asserted mid-second-vector -> no further output; a fresh vector a=2, b=2, last=1 then gives 4.

Source files
------------

// File: rtl/mac_pipe_if.sv
// -----------------------------------------------------------------------------
// mac_pipe_if
//
// Purpose:
//   Bundles the operand stream (valid/ready/last + a/b) and the result stream
//   (valid/ready + data/sat/len_err) of the mac_pipe multiply-accumulate unit.
//
// Signals:
//   in_valid    operand beat valid              (master -> slave)
//   in_ready    unit can accept a beat          (slave  -> master)
//   in_last     final beat of the vector        (master -> slave)
//   a, b        signed operands, BITWIDTH bits  (master -> slave)
//   out_valid   result valid                    (slave  -> master)
//   out_ready   consumer accepts result         (master -> slave)
//   out_data    signed saturated result         (slave  -> master)
//   out_sat     saturation occurred             (slave  -> master)
//   out_len_err vector force-closed at MAX_LEN  (slave  -> master)
//
// Modports:
//   master  the producer/consumer side (e.g. a layer controller)
//   slave   the mac_pipe unit itself
// -----------------------------------------------------------------------------
interface mac_pipe_if #(
  parameter int BITWIDTH  = 8,
  parameter int OUT_WIDTH = 16
);

  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic signed [BITWIDTH-1:0]  a;
  logic signed [BITWIDTH-1:0]  b;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic                        out_len_err;

  // The controlling side drives operands and result acceptance.
  modport master (
    output in_valid, in_last, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_len_err
  );

  // The MAC unit consumes operands and produces results.
  modport slave (
    input  in_valid, in_last, a, b, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_len_err
  );

endinterface

// File: rtl/mac_pipe.sv
// -----------------------------------------------------------------------------
// mac_pipe
//
// Purpose:
//   Pipelined signed multiply-accumulate unit used as a dot-product primitive.
//   Operand pairs stream in with valid/ready and a last flag; their products
//   are accumulated and, on the last beat of each vector, one arithmetically
//   shifted and saturated result is emitted.
//
// Pipeline:
//   P1   registers a, b, last
//   P2   registers the sign-extended 2*BITWIDTH product
//   ACC  adds the product to the accumulator; on a closing beat the sum goes
//        to the result register and the accumulator restarts at zero
//   OUT  shift + saturate, registered onto out_data/out_sat/out_len_err
//   A last beat accepted at edge N shows out_valid=1 after edge N+3.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mac_pipe_if.slave (operand stream in, result stream out)
//
// Parameters:
//   BITWIDTH  signed operand width
//   ACC_WIDTH accumulator width (>= 2*BITWIDTH), wraps silently
//   OUT_WIDTH result width (<= ACC_WIDTH)
//   SHIFT     arithmetic right shift of the final sum (0..ACC_WIDTH-1)
//   MAX_LEN   maximum beats per vector (>= 1); longer vectors are force-closed
//             and flagged with out_len_err
//
// Build option:
//   MAC_PIPE_ROUND_EN  when defined and SHIFT>0, adds 2^(SHIFT-1) before the
//                      shift (round half up). Otherwise the shift floors.
// -----------------------------------------------------------------------------
module mac_pipe #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0,
  parameter int MAX_LEN   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  mac_pipe_if.slave  bus
);

  localparam int PROD_W = 2 * BITWIDTH;
  localparam int CNT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  localparam logic signed [ACC_WIDTH:0] ONE_EXT = 1;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ONE_EXT <<< (OUT_WIDTH - 1)) - ONE_EXT;
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -(ONE_EXT <<< (OUT_WIDTH - 1));

`ifdef MAC_PIPE_ROUND_EN
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND_ADD = (SHIFT > 0) ? (ONE_EXT <<< RND_POS) : '0;
`endif

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // Global stall: every stage advances only when the output register is free
  // or its current result is being taken this cycle.
  logic en;
  logic accept;

  logic                        p1Valid_q;
  logic                        p1Last_q;
  logic signed [BITWIDTH-1:0]  p1A_q;
  logic signed [BITWIDTH-1:0]  p1B_q;

  logic signed [PROD_W-1:0]    prodFull;
  logic signed [ACC_WIDTH-1:0] prodExt;

  logic                        p2Valid_q;
  logic                        p2Last_q;
  logic signed [ACC_WIDTH-1:0] p2Prod_q;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        resValid_q, resValid_d;
  logic signed [ACC_WIDTH-1:0] resSum_q, resSum_d;
  logic                        resLenErr_q, resLenErr_d;

  logic signed [ACC_WIDTH-1:0] sum;
  logic [CNT_W-1:0]            beatsSoFar;
  logic                        forceClose;
  logic                        closeVec;

  logic signed [ACC_WIDTH:0]   sumExt;
  logic signed [ACC_WIDTH:0]   sumRnd;
  logic signed [ACC_WIDTH:0]   shifted;
  logic signed [OUT_WIDTH-1:0] satData;
  logic                        satFlag;

  logic                        outValid_q;
  logic signed [OUT_WIDTH-1:0] outData_q;
  logic                        outSat_q;
  logic                        outLenErr_q;

  assign en           = !outValid_q || bus.out_ready;
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

  // P1 captures the raw operands. The operand registers load every enabled
  // cycle; only the valid bit decides whether the beat means anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1Valid_q <= 1'b0;
      p1Last_q  <= 1'b0;
      p1A_q     <= '0;
      p1B_q     <= '0;
    end else if (en) begin
      p1Valid_q <= accept;
      p1Last_q  <= bus.in_last;
      p1A_q     <= bus.a;
      p1B_q     <= bus.b;
    end
  end

  // Full-precision signed product, sign-extended to accumulator width so the
  // ACC stage is a plain same-width add.
  assign prodFull = p1A_q * p1B_q;
  assign prodExt  = ACC_WIDTH'(prodFull);

  // P2 holds the product so the multiplier and the adder sit in separate
  // pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      p2Valid_q <= 1'b0;
      p2Last_q  <= 1'b0;
      p2Prod_q  <= '0;
    end else if (en) begin
      p2Valid_q <= p1Valid_q;
      p2Last_q  <= p1Last_q;
      p2Prod_q  <= prodExt;
    end
  end

  // The running sum including the beat now in P2. In IDLE the accumulator is
  // already zero, so the same add serves the first beat of a vector.
  assign sum        = acc_q + p2Prod_q;
  assign beatsSoFar = (state_q == IDLE) ? '0 : count_q;
  assign forceClose = !p2Last_q && (beatsSoFar == CNT_LAST);
  assign closeVec   = p2Last_q || forceClose;

  // Vector-tracking FSM and accumulator next state. A closing beat (real last
  // or length limit) hands acc+product to the result register and zeroes the
  // accumulator in the same cycle, so the next vector follows with no bubble.
  // When stalled, everything holds including the pending result.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    resValid_d  = resValid_q;
    resSum_d    = resSum_q;
    resLenErr_d = resLenErr_q;

    if (en) begin
      resValid_d = 1'b0;
      if (p2Valid_q) begin
        case (state_q)
          IDLE: begin
            if (closeVec) begin
              resValid_d  = 1'b1;
              resSum_d    = sum;
              resLenErr_d = forceClose;
              acc_d       = '0;
              count_d     = '0;
              state_d     = IDLE;
            end else begin
              acc_d   = sum;
              count_d = CNT_W'(1);
              state_d = ACCUM;
            end
          end
          ACCUM: begin
            if (closeVec) begin
              resValid_d  = 1'b1;
              resSum_d    = sum;
              resLenErr_d = forceClose;
              acc_d       = '0;
              count_d     = '0;
              state_d     = IDLE;
            end else begin
              acc_d   = sum;
              count_d = count_q + CNT_W'(1);
              state_d = ACCUM;
            end
          end
          default: begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
          end
        endcase
      end
    end
  end

  // State register for the ACC stage and the result register behind it.
  // Reset drops any partial sum and any undelivered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      resValid_q  <= 1'b0;
      resSum_q    <= '0;
      resLenErr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      resValid_q  <= resValid_d;
      resSum_q    <= resSum_d;
      resLenErr_q <= resLenErr_d;
    end
  end

  // Result path: widen by one bit so the optional rounding offset can never
  // wrap, shift arithmetically, then clamp to the signed OUT_WIDTH range.
  always_comb begin
    sumExt = {resSum_q[ACC_WIDTH-1], resSum_q};
`ifdef MAC_PIPE_ROUND_EN
    sumRnd = sumExt + RND_ADD;
`else
    sumRnd = sumExt;
`endif
    shifted = sumRnd >>> SHIFT;
    satData = shifted[OUT_WIDTH-1:0];
    satFlag = 1'b0;
    if (shifted > SAT_MAX) begin
      satData = SAT_MAX[OUT_WIDTH-1:0];
      satFlag = 1'b1;
    end else if (shifted < SAT_MIN) begin
      satData = SAT_MIN[OUT_WIDTH-1:0];
      satFlag = 1'b1;
    end
  end

  // Output register. out_valid follows the result register whenever the pipe
  // moves; data and flags only change when a new result arrives, so they stay
  // put while a result waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outSat_q    <= 1'b0;
      outLenErr_q <= 1'b0;
    end else if (en) begin
      outValid_q <= resValid_q;
      if (resValid_q) begin
        outData_q   <= satData;
        outSat_q    <= satFlag;
        outLenErr_q <= resLenErr_q;
      end
    end
  end

  assign bus.out_valid   = outValid_q;
  assign bus.out_data    = outData_q;
  assign bus.out_sat     = outSat_q;
  assign bus.out_len_err = outLenErr_q;

endmodule

// File: tb/tb_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_mac_pipe
//
// Drives two mac_pipe instances from one shared operand stream:
//   dut0  default parameters (SHIFT=0, MAX_LEN=1024)
//   dut1  SHIFT=2, MAX_LEN=4 (shift/rounding and length-limit behaviour)
// A transaction-level model per instance turns every accepted beat into the
// expected result list; a single negedge process compares each delivered
// result against it and also checks that held results stay stable. Directed
// phases add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_mac_pipe;

  localparam int SHIFT1  = 2;
  localparam int MAXLEN1 = 4;

`ifdef MAC_PIPE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    longint data;
    bit     sat;
    bit     lenErr;
    longint cyc;
  } res_t;

  logic              clk;
  logic              rst;
  logic              inValid;
  logic              inLast;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              outReady;

  logic [1:0]         inRdyW;
  logic [1:0]         outValW;
  logic [1:0]         satW;
  logic [1:0]         lenW;
  logic signed [15:0] dataW [2];

  int     checks;
  int     failures;
  longint cycle;

  res_t   expQ [2][$];
  res_t   obsQ [2][$];
  longint modelSum [2];
  int     modelCnt [2];
  bit     held [2];
  longint heldData [2];
  bit     heldSat [2];
  bit     heldLen [2];
  res_t   eRes;
  res_t   oRes;

  mac_pipe_if #(.BITWIDTH(8), .OUT_WIDTH(16)) if0 ();
  mac_pipe_if #(.BITWIDTH(8), .OUT_WIDTH(16)) if1 ();

  mac_pipe #(
    .BITWIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(0), .MAX_LEN(1024)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(if0)
  );

  mac_pipe #(
    .BITWIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(SHIFT1), .MAX_LEN(MAXLEN1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(if1)
  );

  assign if0.in_valid  = inValid;
  assign if0.in_last   = inLast;
  assign if0.a         = a;
  assign if0.b         = b;
  assign if0.out_ready = outReady;
  assign if1.in_valid  = inValid;
  assign if1.in_last   = inLast;
  assign if1.a         = a;
  assign if1.b         = b;
  assign if1.out_ready = outReady;

  assign inRdyW  = {if1.in_ready, if0.in_ready};
  assign outValW = {if1.out_valid, if0.out_valid};
  assign satW    = {if1.out_sat, if0.out_sat};
  assign lenW    = {if1.out_len_err, if0.out_len_err};
  assign dataW[0] = if0.out_data;
  assign dataW[1] = if1.out_data;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int shiftOf(input int k);
    return (k == 0) ? 0 : SHIFT1;
  endfunction

  function automatic int maxLenOf(input int k);
    return (k == 0) ? 1024 : MAXLEN1;
  endfunction

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  // Final-sum to output value: optional round-half-up, floor shift, clamp.
  function automatic res_t makeResult(input longint s, input int sh, input bit lenErr);
    res_t   r;
    longint v;
    v = s;
    if (ROUND && sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    r.sat = 1'b0;
    if (v > 32767) begin
      v = 32767;
      r.sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      r.sat = 1'b1;
    end
    r.data   = v;
    r.lenErr = lenErr;
    r.cyc    = 0;
    return r;
  endfunction

  // Model and compare: each negedge, inputs and outputs are stable for the
  // coming edge. A delivered result is checked against the model's queue, a
  // held result must not change, and an accepted beat feeds the model.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        expQ[k].delete();
        modelSum[k] = 0;
        modelCnt[k] = 0;
        held[k]     = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (held[k]) begin
          checkOutput($sformatf("holdValid%0d", k), longint'(outValW[k]), 1);
          checkOutput($sformatf("holdData%0d", k), longint'(dataW[k]), heldData[k]);
          checkOutput($sformatf("holdSat%0d", k), longint'(satW[k]), longint'(heldSat[k]));
          checkOutput($sformatf("holdLen%0d", k), longint'(lenW[k]), longint'(heldLen[k]));
        end
        if (outValW[k] && outReady) begin
          if (expQ[k].size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected%0d: got result %0d, expected no result", k, dataW[k]);
          end else begin
            eRes = expQ[k].pop_front();
            checkOutput($sformatf("resData%0d", k), longint'(dataW[k]), eRes.data);
            checkOutput($sformatf("resSat%0d", k), longint'(satW[k]), longint'(eRes.sat));
            checkOutput($sformatf("resLen%0d", k), longint'(lenW[k]), longint'(eRes.lenErr));
          end
          oRes.data   = longint'(dataW[k]);
          oRes.sat    = satW[k];
          oRes.lenErr = lenW[k];
          oRes.cyc    = cycle;
          obsQ[k].push_back(oRes);
        end
        held[k]     = outValW[k] && !outReady;
        heldData[k] = longint'(dataW[k]);
        heldSat[k]  = satW[k];
        heldLen[k]  = lenW[k];
        if (inValid && inRdyW[k]) begin
          modelSum[k] = wrap32(modelSum[k] + longint'(a) * longint'(b));
          modelCnt[k]++;
          if (inLast || modelCnt[k] == maxLenOf(k)) begin
            expQ[k].push_back(makeResult(modelSum[k], shiftOf(k), !inLast));
            modelSum[k] = 0;
            modelCnt[k] = 0;
          end
        end
      end
    end
  end

  // One beat: present it, wait (bounded) for in_ready, let the edge take it.
  task automatic applyStimulus(input int av, input int bv, input bit last);
    int tries;
    tries   = 0;
    inValid = 1'b1;
    a       = 8'(av);
    b       = 8'(bv);
    inLast  = last;
    @(negedge clk);
    while (!inRdyW[0] && tries < 50) begin
      tries++;
      @(negedge clk);
    end
    if (tries >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL beatTimeout: got in_ready=0 for %0d cycles, expected acceptance", tries);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inValid = 1'b0;
    inLast  = 1'b0;
    a       = '0;
    b       = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearObs();
    obsQ[0].delete();
    obsQ[1].delete();
  endtask

  task automatic checkObs(input int k, input int idx, input longint d, input bit s, input bit l);
    if (idx >= obsQ[k].size()) begin
      checks++;
      failures++;
      $display("[TB] FAIL obsMissing%0d_%0d: got %0d results, expected index %0d", k, idx, obsQ[k].size(), idx);
    end else begin
      checkOutput($sformatf("obsData%0d_%0d", k, idx), obsQ[k][idx].data, d);
      checkOutput($sformatf("obsSat%0d_%0d", k, idx), longint'(obsQ[k][idx].sat), longint'(s));
      checkOutput($sformatf("obsLen%0d_%0d", k, idx), longint'(obsQ[k][idx].lenErr), longint'(l));
    end
  endtask

  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    cycle    = 0;
    rst      = 1'b1;
    outReady = 1'b1;
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rstOutValid0", longint'(outValW[0]), 0);
    checkOutput("rstOutValid1", longint'(outValW[1]), 0);
    checkOutput("rstInReady0", longint'(inRdyW[0]), 1);
    checkOutput("rstData0", longint'(dataW[0]), 0);
    checkOutput("rstSat0", longint'(satW[0]), 0);
    checkOutput("rstLen0", longint'(lenW[0]), 0);
    @(posedge clk);
    #1;

    // Single beat 3*4 and its latency.
    clearObs();
    applyStimulus(3, 4, 1'b1);
    idleInputs();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (outValW[0]) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", lat, 3);
    drain(4);
    checkObs(0, 0, 12, 1'b0, 1'b0);

    // Back-to-back vectors: 20 then -35 with no bubble.
    clearObs();
    applyStimulus(1, 2, 1'b0);
    applyStimulus(2, 2, 1'b0);
    applyStimulus(3, 2, 1'b0);
    applyStimulus(4, 2, 1'b1);
    applyStimulus(-5, 7, 1'b1);
    idleInputs();
    drain(8);
    checkOutput("b2bCount", obsQ[0].size(), 2);
    checkObs(0, 0, 20, 1'b0, 1'b0);
    checkObs(0, 1, -35, 1'b0, 1'b0);
    if (obsQ[0].size() >= 2) checkOutput("noBubble", obsQ[0][1].cyc - obsQ[0][0].cyc, 1);

    // Saturation both ways.
    clearObs();
    repeat (3) applyStimulus(-128, -128, 1'b0);
    applyStimulus(-128, -128, 1'b1);
    applyStimulus(127, -128, 1'b0);
    applyStimulus(127, -128, 1'b0);
    applyStimulus(127, -128, 1'b1);
    idleInputs();
    drain(8);
    checkObs(0, 0, 32767, 1'b1, 1'b0);
    checkObs(0, 1, -32768, 1'b1, 1'b0);
    checkObs(1, 0, 16384, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles, pipe stalled.
    clearObs();
    outReady = 1'b0;
    applyStimulus(5, 5, 1'b1);
    applyStimulus(6, 6, 1'b1);
    idleInputs();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (outValW[0]) begin
        lat = i;
        break;
      end
    end
    checkOutput("stallArrive", longint'(outValW[0]), 1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stallInReady", longint'(inRdyW[0]), 0);
      checkOutput("stallData", longint'(dataW[0]), 25);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    drain(6);
    checkObs(0, 0, 25, 1'b0, 1'b0);
    checkObs(0, 1, 36, 1'b0, 1'b0);

    // Shift on dut1: sums 6 and -6.
    clearObs();
    applyStimulus(2, 3, 1'b1);
    applyStimulus(-2, 3, 1'b1);
    idleInputs();
    drain(8);
    checkObs(1, 0, ROUND ? 2 : 1, 1'b0, 1'b0);
    checkObs(1, 1, ROUND ? -1 : -2, 1'b0, 1'b0);

    // Length limit on dut1 (MAX_LEN=4): six beats of 2*2, no last.
    clearObs();
    repeat (6) applyStimulus(2, 2, 1'b0);
    idleInputs();
    drain(8);
    checkOutput("lenCount1", obsQ[1].size(), 1);
    checkOutput("lenCount0", obsQ[0].size(), 0);
    checkObs(1, 0, 4, 1'b0, 1'b1);

    // Reset mid-vector discards partial sums; a fresh vector starts from 0.
    clearObs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain(6);
    checkOutput("postRstNone0", obsQ[0].size(), 0);
    checkOutput("postRstNone1", obsQ[1].size(), 0);
    applyStimulus(4, 4, 1'b1);
    idleInputs();
    drain(8);
    checkObs(0, 0, 16, 1'b0, 1'b0);
    checkObs(1, 0, 4, 1'b0, 1'b0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      a        = 8'($urandom);
      b        = 8'($urandom);
      inLast   = ($urandom_range(0, 4) == 0);
      outReady = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    idleInputs();
    outReady = 1'b1;
    drain(12);
    checkOutput("pendingExp0", expQ[0].size(), 0);
    checkOutput("pendingExp1", expQ[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
